// File: rtl/fc_mac_layer.sv
// fc_mac_layer: sequential fully-connected layer. Each accepted beat
// MACs one activation into OUT parallel neuron accumulators.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   clr             abort the frame being accumulated (ignored in HOLD)
//   x_valid/x_ready activation beat handshake
//   x_data          signed activation
//   w_data[n]       signed weight of neuron n for x_data
//   bias[n]         signed bias, used on the first beat of a frame
//   in_idx          index of the next expected beat (weight-ROM addr)
//   z_valid/z_ready result handshake
//   z[n]            result of neuron n (ReLU-clamped when RELU=1)
module fc_mac_layer #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int OUT   = 4,
  parameter int RELU  = 1,
  localparam int ACC_W = 2*WIDTH + $clog2(IN+1),
  localparam int IDX_W = $clog2(IN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [WIDTH-1:0]   x_data,
  input  logic [WIDTH-1:0]   w_data [0:OUT-1],
  input  logic [2*WIDTH-1:0] bias   [0:OUT-1],
  output logic [IDX_W-1:0]   in_idx,
  output logic               z_valid,
  input  logic               z_ready,
  output logic [ACC_W-1:0]   z      [0:OUT-1]
);

  localparam int EXT_W = ACC_W - 2*WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(IN-1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]   r_idx;
  logic [ACC_W-1:0]   r_acc [OUT];
  logic [ACC_W-1:0]   r_z   [OUT];
  logic [ACC_W-1:0]   w_sum [OUT];
  logic [ACC_W-1:0]   w_res [OUT];
  logic [2*WIDTH-1:0] w_xs;
  logic               w_open;
  logic               w_beat;
  logic               w_first;
  logic               w_last;

  // clr blocks the beat outright so it can never race the index reset.
  assign w_open  = (r_state == ACCUM) && !clr;
  assign w_beat  = x_valid && w_open;
  assign w_first = (r_idx == '0);
  assign w_last  = (r_idx == LAST);

  assign x_ready = w_open;
  assign in_idx  = r_idx;

  // Sign-extending both operands to 2*WIDTH makes the low half of an
  // unsigned multiply equal the exact signed product.
  assign w_xs = {{WIDTH{x_data[WIDTH-1]}}, x_data};

  for (genvar n = 0; n < OUT; n++) begin : g_mac
    logic [2*WIDTH-1:0] w_ws;
    logic [2*WIDTH-1:0] w_prod;
    logic [ACC_W-1:0]   w_pext;
    logic [ACC_W-1:0]   w_bext;
    logic [ACC_W-1:0]   w_base;

    assign w_ws   = {{WIDTH{w_data[n][WIDTH-1]}}, w_data[n]};
    assign w_prod = w_xs * w_ws;
    assign w_pext = {{EXT_W{w_prod[2*WIDTH-1]}}, w_prod};
    assign w_bext = {{EXT_W{bias[n][2*WIDTH-1]}}, bias[n]};

    // First beat seeds from the bias instead of the stale accumulator.
    assign w_base   = w_first ? w_bext : r_acc[n];
    assign w_sum[n] = w_base + w_pext;
    assign w_res[n] = ((RELU != 0) && w_sum[n][ACC_W-1]) ?
                      '0 : w_sum[n];
    assign z[n]     = r_z[n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    z_valid = 1'b0;
    unique case (r_state)
      ACCUM: begin
        if (w_beat && w_last) begin
          w_next = HOLD;
        end
      end
      HOLD: begin
        z_valid = 1'b1;
        if (z_ready) begin
          w_next = ACCUM;
        end
      end
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      for (int n = 0; n < OUT; n++) begin
        r_acc[n] <= '0;
        r_z[n]   <= '0;
      end
    end else if (clr && (r_state == ACCUM)) begin
      r_idx <= '0;
    end else if (w_beat) begin
      for (int n = 0; n < OUT; n++) begin
        r_acc[n] <= w_sum[n];
      end
      if (w_last) begin
        r_idx <= '0;
        for (int n = 0; n < OUT; n++) begin
          r_z[n] <= w_res[n];
        end
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_layer.sv
// tb_fc_mac_layer: scoreboard bench for fc_mac_layer. A small IN=4
// instance covers handshakes; an IN=128 ReLU instance covers extremes.
module tb_fc_mac_layer;

  localparam int ACC1 = 16 + $clog2(5);
  localparam int ACC2 = 16 + $clog2(129);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clr, x_valid, x_ready, z_valid, z_ready;
  logic [7:0]      x_data;
  logic [7:0]      w_data [0:1];
  logic [15:0]     bias   [0:1];
  logic [1:0]      in_idx;
  logic [ACC1-1:0] z      [0:1];

  logic            clr2, x2_valid, x2_ready, z2_valid, z2_ready;
  logic [7:0]      x2_data;
  logic [7:0]      w2_data [0:1];
  logic [15:0]     bias2   [0:1];
  logic [6:0]      in_idx2;
  logic [ACC2-1:0] z2      [0:1];

  fc_mac_layer #(.WIDTH(8), .IN(4), .OUT(2), .RELU(0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .w_data(w_data), .bias(bias), .in_idx(in_idx),
    .z_valid(z_valid), .z_ready(z_ready), .z(z)
  );

  fc_mac_layer #(.WIDTH(8), .IN(128), .OUT(2), .RELU(1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2),
    .x_valid(x2_valid), .x_ready(x2_ready), .x_data(x2_data),
    .w_data(w2_data), .bias(bias2), .in_idx(in_idx2),
    .z_valid(z2_valid), .z_ready(z2_ready), .z(z2)
  );

  int checks = 0;
  int failures = 0;

  int fx [4];
  int fw [4][2];
  int fb [2];

  logic [ACC1-1:0] exp_q [$];
  logic [ACC2-1:0] exp2_q [$];

  task automatic set_rand();
    for (int i = 0; i < 4; i++) begin
      fx[i] = int'($urandom_range(0, 255)) - 128;
      fw[i][0] = int'($urandom_range(0, 255)) - 128;
      fw[i][1] = int'($urandom_range(0, 255)) - 128;
    end
    fb[0] = int'($urandom_range(0, 2000)) - 1000;
    fb[1] = int'($urandom_range(0, 2000)) - 1000;
  endtask

  task automatic set_base();
    for (int i = 0; i < 4; i++) begin
      fx[i] = i + 1;
      fw[i][0] = 1;
      fw[i][1] = (i == 0) ? -2 : 0;
    end
    fb[0] = 5;
    fb[1] = -1;
  endtask

  // Reference model: plain integer dot product plus bias (RELU=0).
  task automatic push_expected();
    for (int n = 0; n < 2; n++) begin
      int s;
      s = fb[n];
      for (int i = 0; i < 4; i++) s += fx[i] * fw[i][n];
      exp_q.push_back(ACC1'(s));
    end
  endtask

  // Called at a negedge; returns at the negedge after the last accepted
  // beat with x_valid low. idx_err counts in_idx disagreements.
  task automatic drive_beats(input int nb, input bit bub,
                             output int idx_err, output int cyc);
    int i;
    bit acc;
    i = 0;
    cyc = 0;
    idx_err = 0;
    while (i < nb && cyc < 500) begin
      cyc++;
      x_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      x_data = 8'(fx[i]);
      w_data[0] = 8'(fw[i][0]);
      w_data[1] = 8'(fw[i][1]);
      bias[0] = 16'(fb[0]);
      bias[1] = 16'(fb[1]);
      #1;
      if (in_idx !== 2'(i)) idx_err++;
      acc = x_valid && x_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
    end
    x_valid = 1'b0;
    if (i < nb) idx_err += 1000;
  endtask

  task automatic wait_z(output bit to);
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (z_valid === 1'b1) begin
        to = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    z_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (z_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_zvalid got=%b exp=0", z_valid);
    end
    checks++;
    if (in_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_idx got=%0d exp=0", in_idx);
    end
    checks++;
    if (x_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_xready got=%b exp=1", x_ready);
    end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (z[n] !== '0) begin
        failures++;
        $display("FAIL reset_z%0d got=%0h exp=0", n, z[n]);
      end
    end
  endtask

  task automatic test_baseline();
    int err, cyc;
    logic [ACC1-1:0] e;
    set_base();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    checks++;
    if (err !== 0 || cyc !== 4) begin
      failures++;
      $display("FAIL base_beats err=%0d cyc=%0d exp 0/4", err, cyc);
    end
    checks++;
    if (z_valid !== 1'b1) begin
      failures++;
      $display("FAIL base_latency z_valid=%b exp=1", z_valid);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (x_ready !== 1'b0) begin
        failures++;
        $display("FAIL base_hold_xready got=%b exp=0", x_ready);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (z[n] !== e) begin
        failures++;
        $display("FAIL base_z%0d got=%0d exp=%0d", n,
                 $signed(z[n]), $signed(e));
      end
    end
    checks++;
    if (z[1] !== ACC1'(-3)) begin
      failures++;
      $display("FAIL base_const_z1 got=%0d exp=-3", $signed(z[1]));
    end
    accept();
  endtask

  task automatic test_backpressure();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e;
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    checks++;
    if (to || err !== 0) begin
      failures++;
      $display("FAIL bp_frame to=%b err=%0d exp 0/0", to, err);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (z[0] !== exp_q[0] || z[1] !== exp_q[1] ||
          x_ready !== 1'b0 || z_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d z=%0h,%0h exp=%0h,%0h xr=%b zv=%b",
                 k, z[0], z[1], exp_q[0], exp_q[1], x_ready, z_valid);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (z[n] !== e) begin
        failures++;
        $display("FAIL bp_z%0d got=%0h exp=%0h", n, z[n], e);
      end
    end
    accept();
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    checks++;
    if (cyc !== 4 || err !== 0) begin
      failures++;
      $display("FAIL b2b_accept cyc=%0d err=%0d exp 4/0", cyc, err);
    end
    wait_z(to);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (to || z[n] !== e) begin
        failures++;
        $display("FAIL b2b_z%0d got=%0h exp=%0h to=%b", n, z[n], e, to);
      end
    end
    accept();
  endtask

  task automatic test_bubbles();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e;
    set_base();
    push_expected();
    drive_beats(4, 1'b1, err, cyc);
    checks++;
    if (err !== 0) begin
      failures++;
      $display("FAIL bub_idx got=%0d exp=0", err);
    end
    wait_z(to);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (to || z[n] !== e) begin
        failures++;
        $display("FAIL bub_z%0d got=%0h exp=%0h to=%b", n, z[n], e, to);
      end
    end
    accept();
  endtask

  task automatic test_clr();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e;
    set_rand();
    drive_beats(2, 1'b0, err, cyc);
    clr = 1'b1;
    #1;
    checks++;
    if (x_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_xready got=%b exp=0", x_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (in_idx !== 2'd0) begin
      failures++;
      $display("FAIL clr_idx got=%0d exp=0", in_idx);
    end
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (to || z[n] !== e) begin
        failures++;
        $display("FAIL clr_z%0d got=%0h exp=%0h to=%b", n, z[n], e, to);
      end
    end
    accept();
  endtask

  task automatic test_clr_coincident();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e;
    set_rand();
    clr = 1'b1;
    x_valid = 1'b1;
    x_data = 8'(fx[0]);
    w_data[0] = 8'(fw[0][0]);
    w_data[1] = 8'(fw[0][1]);
    #1;
    checks++;
    if (x_ready !== 1'b0) begin
      failures++;
      $display("FAIL clrx_xready got=%b exp=0", x_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    x_valid = 1'b0;
    #1;
    checks++;
    if (in_idx !== 2'd0) begin
      failures++;
      $display("FAIL clrx_idx got=%0d exp=0", in_idx);
    end
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (to || z[n] !== e) begin
        failures++;
        $display("FAIL clrx_z%0d got=%0h exp=%0h to=%b", n, z[n], e, to);
      end
    end
    accept();
  endtask

  task automatic test_clr_hold();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e0, e1;
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    checks++;
    if (to || z_valid !== 1'b1 || z[0] !== e0 || z[1] !== e1) begin
      failures++;
      $display("FAIL clrh_z got=%0h,%0h zv=%b exp=%0h,%0h zv=1",
               z[0], z[1], z_valid, e0, e1);
    end
    accept();
    checks++;
    if (z_valid !== 1'b0 || z[0] !== e0 || z[1] !== e1) begin
      failures++;
      $display("FAIL post_accept z=%0h,%0h zv=%b exp=%0h,%0h zv=0",
               z[0], z[1], z_valid, e0, e1);
    end
  endtask

  task automatic test_rst_mid();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e;
    set_rand();
    drive_beats(2, 1'b0, err, cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (z_valid !== 1'b0 || in_idx !== 2'd0 ||
        z[0] !== '0 || z[1] !== '0) begin
      failures++;
      $display("FAIL rstm got zv=%b idx=%0d z=%0h,%0h exp 0/0/0,0",
               z_valid, in_idx, z[0], z[1]);
    end
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (to || z[n] !== e) begin
        failures++;
        $display("FAIL rstm_z%0d got=%0h exp=%0h to=%b", n, z[n], e, to);
      end
    end
    accept();
  endtask

  task automatic test_rst_hold();
    int err, cyc;
    bit to;
    logic [ACC1-1:0] e;
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (to || z_valid !== 1'b0 || in_idx !== 2'd0 ||
        z[0] !== '0 || z[1] !== '0) begin
      failures++;
      $display("FAIL rsth got zv=%b idx=%0d z=%0h,%0h to=%b exp 0",
               z_valid, in_idx, z[0], z[1], to);
    end
    set_rand();
    push_expected();
    drive_beats(4, 1'b0, err, cyc);
    wait_z(to);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (to || z[n] !== e) begin
        failures++;
        $display("FAIL rsth_z%0d got=%0h exp=%0h to=%b", n, z[n], e, to);
      end
    end
    accept();
  endtask

  task automatic test_relu_extremes();
    int got, cyc;
    logic [ACC2-1:0] e;
    exp2_q.push_back(ACC2'(0));
    exp2_q.push_back(ACC2'(2097152));
    x2_data = 8'h80;
    w2_data[0] = 8'h7f;
    w2_data[1] = 8'h80;
    bias2[0] = '0;
    bias2[1] = '0;
    got = 0;
    cyc = 0;
    while (got < 128 && cyc < 400) begin
      cyc++;
      x2_valid = 1'b1;
      #1;
      if (x2_ready === 1'b1) got++;
      @(negedge clk);
    end
    x2_valid = 1'b0;
    cyc = 0;
    while (z2_valid !== 1'b1 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (z2_valid !== 1'b1 || in_idx2 !== 7'd0) begin
      failures++;
      $display("FAIL relu_done zv=%b idx=%0d exp 1/0", z2_valid, in_idx2);
    end
    for (int n = 0; n < 2; n++) begin
      e = exp2_q.pop_front();
      checks++;
      if (z2[n] !== e) begin
        failures++;
        $display("FAIL relu_z%0d got=%0d exp=%0d", n, z2[n], e);
      end
    end
    z2_ready = 1'b1;
    @(negedge clk);
    z2_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    x_valid = 1'b0;
    z_ready = 1'b0;
    x_data = '0;
    w_data[0] = '0;
    w_data[1] = '0;
    bias[0] = '0;
    bias[1] = '0;
    clr2 = 1'b0;
    x2_valid = 1'b0;
    z2_ready = 1'b0;
    x2_data = '0;
    w2_data[0] = '0;
    w2_data[1] = '0;
    bias2[0] = '0;
    bias2[1] = '0;
    @(negedge clk);
    test_reset();
    test_baseline();
    test_backpressure();
    test_bubbles();
    test_clr();
    test_clr_coincident();
    test_clr_hold();
    test_rst_mid();
    test_rst_hold();
    test_relu_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
